sm_regdump_uart: RTL and testbench



---
 rtl/sm_regdump_uart.sv | 124 ++++++++++++
 tb/tb_sm_regdump_uart.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_regdump_uart.sv
// Register dump engine: sweeps the CPU debug port over addresses 0..31 and sends
// each captured value out as 8 uppercase hex digits plus newline on a UART 8N1 line.
module sm_regdump_uart #(
   parameter int BAUD_DIV = 434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] regData,
   output logic [4:0]  regAddr,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam int CW = $clog2(BAUD_DIV);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_CAPTURE,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [31:0]     r_shadow;
   logic [3:0]      r_charIdx;
   logic [3:0]      r_bitIdx;
   logic [CW-1:0]   r_baudCnt;
   logic [8:0]      r_shift;

   logic [3:0]      w_nibble;
   logic [7:0]      w_hex;
   logic [7:0]      w_byte;
   logic            w_bitEnd;

   // Char index 0..7 walks the shadow MSB nibble first; index 8 is the newline.
   always_comb begin
      w_nibble = r_shadow[{3'd7 - r_charIdx[2:0], 2'b00} +: 4];
      w_hex    = (w_nibble < 4'd10) ? (8'h30 + {4'd0, w_nibble})
                                    : (8'h37 + {4'd0, w_nibble});
      w_byte   = (r_charIdx == 4'd8) ? 8'h0A : w_hex;
      w_bitEnd = (r_baudCnt == CW'(BAUD_DIV - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_shadow  <= '0;
         r_charIdx <= '0;
         r_bitIdx  <= '0;
         r_baudCnt <= '0;
         r_shift   <= '1;
         regAddr   <= '0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               tx   <= 1'b1;
               busy <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  regAddr <= '0;
                  busy    <= 1'b1;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               r_shadow  <= regData;
               r_charIdx <= '0;
               r_state   <= S_LOAD;
            end
            // The start bit goes on the line together with loading the frame.
            S_LOAD: begin
               r_shift   <= {1'b1, w_byte};
               tx        <= 1'b0;
               r_baudCnt <= '0;
               r_bitIdx  <= '0;
               r_state   <= S_SHIFT;
            end
            S_SHIFT: begin
               if (w_bitEnd) begin
                  r_baudCnt <= '0;
                  if (r_bitIdx == 4'd9) begin
                     tx <= 1'b1;
                     if (r_charIdx < 4'd8) begin
                        r_charIdx <= r_charIdx + 4'd1;
                        r_state   <= S_LOAD;
                     end else if (regAddr != 5'd31) begin
                        regAddr <= regAddr + 5'd1;
                        r_state <= S_SETUP;
                     end else begin
                        done    <= 1'b1;
                        r_state <= S_DONE;
                     end
                  end else begin
                     r_bitIdx <= r_bitIdx + 4'd1;
                     tx       <= r_shift[0];
                     r_shift  <= {1'b1, r_shift[8:1]};
                  end
               end else begin
                  r_baudCnt <= r_baudCnt + CW'(1);
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sm_regdump_uart.sv
// Bench for sm_regdump_uart: drives a modelled register file, decodes the UART
// line and compares the byte stream and handshake timing against a reference.
module tb_sm_regdump_uart;

   localparam int BD          = 4;
   localparam int DUMP_CYCLES = 32 * (2 + 9 * (1 + 10 * BD)) + 1;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] regData;
   logic [4:0]  regAddr;
   logic        tx;
   logic        busy;
   logic        done;

   sm_regdump_uart #(.BAUD_DIV(BD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .regData (regData),
      .regAddr (regAddr),
      .tx      (tx),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // Register file model: mode 0 = 0xDEADBE00|addr, 1 = constant, 2 = random table.
   int          mode    = 0;
   int          latency = 0;
   logic [31:0] randTab [32];
   logic [31:0] combVal;
   logic [31:0] latVal  = '0;

   always_comb begin
      case (mode)
         0:       combVal = 32'hDEADBE00 | {27'd0, regAddr};
         1:       combVal = 32'hFEDCBA98;
         default: combVal = randTab[regAddr];
      endcase
   end

   always @(posedge clk) latVal <= combVal;

   assign regData = (latency != 0) ? latVal : combVal;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Line decoder and handshake counters, sampled on the falling edge.
   int          doneCnt   = 0;
   int          doneCyc   = 0;
   int          busyCnt   = 0;
   int          rxBadStop = 0;
   logic        rxActive  = 1'b0;
   int          rxCnt     = 0;
   logic [7:0]  rxShift   = '0;
   logic [7:0]  rxQ [$];

   always @(negedge clk) begin
      if (!rst_n) begin
         rxActive <= 1'b0;
         rxCnt    <= 0;
      end else begin
         if (done) begin
            doneCnt <= doneCnt + 1;
            doneCyc <= cyc;
         end
         if (busy) busyCnt <= busyCnt + 1;
         if (!rxActive) begin
            if (tx == 1'b0) begin
               rxActive <= 1'b1;
               rxCnt    <= 1;
            end
         end else begin
            rxCnt <= rxCnt + 1;
            if (rxCnt > BD && rxCnt < 9 * BD && (rxCnt % BD) == BD / 2)
               rxShift <= {tx, rxShift[7:1]};
            if (rxCnt == 9 * BD + BD / 2) begin
               if (tx) rxQ.push_back(rxShift);
               else rxBadStop <= rxBadStop + 1;
               rxActive <= 1'b0;
            end
         end
      end
   end

   int         testsRun    = 0;
   int         testsFailed = 0;
   int         busyBase, doneBase, rxBase, stopBase, startCyc;
   logic [7:0] expQ [$];

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] refVal(input int a);
      case (mode)
         0:       return 32'hDEADBE00 | 32'(a);
         1:       return 32'hFEDCBA98;
         default: return randTab[a];
      endcase
   endfunction

   task automatic buildExpected();
      string       hexDigits = "0123456789ABCDEF";
      logic [31:0] v;
      logic [3:0]  nib;
      expQ.delete();
      for (int a = 0; a < 32; a++) begin
         v = refVal(a);
         for (int i = 7; i >= 0; i--) begin
            nib = v[i*4 +: 4];
            expQ.push_back(hexDigits[nib]);
         end
         expQ.push_back(8'h0A);
      end
   endtask

   task automatic takeBases();
      busyBase = busyCnt;
      doneBase = doneCnt;
      rxBase   = rxQ.size();
      stopBase = rxBadStop;
   endtask

   // Pulses start for one edge; returns #1 into the first busy cycle.
   task automatic applyStimulus();
      buildExpected();
      @(negedge clk);
      start = 1'b1;
      #1;
      takeBases();
      @(negedge clk);
      start = 1'b0;
      #1;
      startCyc = cyc;
   endtask

   task automatic waitDone(input string tag);
      int n;
      int mism;
      for (int i = 0; i < DUMP_CYCLES + 200 && doneCnt == doneBase; i++) begin
         @(negedge clk);
         #1;
      end
      checkOutput({tag, "_done_count"}, doneCnt - doneBase, 1);
      checkOutput({tag, "_done_cycle"}, doneCyc - startCyc + 1, DUMP_CYCLES);
      checkOutput({tag, "_busy_cycles"}, busyCnt - busyBase, DUMP_CYCLES);
      n    = rxQ.size() - rxBase;
      mism = 0;
      for (int i = 0; i < n && i < expQ.size(); i++)
         if (rxQ[rxBase + i] !== expQ[i]) mism++;
      checkOutput({tag, "_byte_count"}, n, 288);
      checkOutput({tag, "_byte_errors"}, mism, 0);
      checkOutput({tag, "_stop_errors"}, rxBadStop - stopBase, 0);
   endtask

   task automatic waitBytes(input string tag, input int target);
      for (int i = 0; i < DUMP_CYCLES && (rxQ.size() - rxBase) < target; i++) begin
         @(negedge clk);
         #1;
      end
      checkOutput(tag, (rxQ.size() - rxBase) >= target, 1);
   endtask

   initial begin
      int          viol;
      logic [63:0] gotBits;
      logic [63:0] expBits;
      logic [7:0]  firstChar;
      int          j;

      for (int i = 0; i < 32; i++) randTab[i] = $urandom();

      viol = 0;
      repeat (3) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || regAddr !== 5'd0) viol++;
      end
      rst_n = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || regAddr !== 5'd0) viol++;
      end
      checkOutput("reset_idle", viol, 0);

      // First frame bit timing plus full dump with the address-tagged model.
      mode = 0;
      latency = 0;
      applyStimulus();
      checkOutput("first_busy", busy, 1);
      checkOutput("first_addr", regAddr, 0);
      firstChar = expQ[0];
      gotBits = '0;
      expBits = '0;
      for (int k = 1; k <= 43; k++) begin
         gotBits[k] = tx;
         if (k <= 3) expBits[k] = 1'b1;
         else begin
            j = (k - 4) / BD;
            if (j == 0)      expBits[k] = 1'b0;
            else if (j <= 8) expBits[k] = firstChar[j-1];
            else             expBits[k] = 1'b1;
         end
         @(negedge clk);
         #1;
      end
      checkOutput("first_frame_bits", gotBits, expBits);
      waitDone("dump_deadbe");
      @(negedge clk);
      #1;
      checkOutput("deadbe_busy_fall", busy, 0);

      // All-digit value with one cycle of read latency.
      mode = 1;
      latency = 1;
      repeat (5) @(negedge clk);
      applyStimulus();
      waitDone("dump_fedcba");
      @(negedge clk);
      #1;
      checkOutput("fedcba_busy_fall", busy, 0);

      // Random table; stray start mid-dump, then start held across DONE.
      mode = 2;
      latency = 0;
      repeat (5) @(negedge clk);
      applyStimulus();
      waitBytes("reach_reg4_char2", 38);
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitBytes("reach_last_reg", 280);
      start = 1'b1;
      waitDone("dump_rand_a");
      @(negedge clk);
      #1;
      checkOutput("held_idle_gap", busy, 0);
      takeBases();
      @(negedge clk);
      #1;
      checkOutput("held_restart", busy, 1);
      startCyc = cyc;
      start = 1'b0;
      buildExpected();
      waitDone("dump_rand_b");
      @(negedge clk);
      #1;
      checkOutput("rand_busy_fall", busy, 0);

      // Asynchronous reset in the middle of a data bit of register 7.
      mode = 0;
      repeat (5) @(negedge clk);
      applyStimulus();
      waitBytes("reach_reg7_char2", 65);
      for (int i = 0; i < 200 && !(rxActive && rxCnt == 3 * BD + 1); i++) begin
         @(negedge clk);
         #1;
      end
      checkOutput("pre_rst_addr", regAddr, 7);
      checkOutput("pre_rst_in_bit", rxActive && rxCnt == 3 * BD + 1, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_tx", tx, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_addr", regAddr, 0);
      checkOutput("rst_done", done, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      checkOutput("rst_no_done", doneCnt - doneBase, 0);
      applyStimulus();
      waitDone("dump_after_rst");
      @(negedge clk);
      #1;
      checkOutput("after_rst_busy_fall", busy, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
